// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side adapter turning a read-strobe FIFO into a valid/ready stream
//
// Purpose:
//   Issues one-word reads to a FIFO with one cycle of read latency and presents the
//   returned words on a valid/ready output stream. A two-entry buffer (head, skid)
//   absorbs the read latency, so full throughput is sustained while m_ready is high.
//   A read is only issued when the buffer is certain to have room for the returning word.
//
// Optional feature:
//   FIFO_READER_COUNT_EN - when defined, adds the words_out port and the delivered-word counter.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   enable     - permits new FIFO reads while high
//   fifo_empty - FIFO empty status, reflects all earlier reads
//   fifo_data  - FIFO read data, valid the cycle after fifo_re
//   fifo_re    - one-word FIFO read strobe
//   m_data     - output stream data (buffer head)
//   m_valid    - output stream valid
//   m_ready    - output stream ready
//   busy       - high whenever the controller is not idle
//   words_out  - delivered-word count, wraps (FIFO_READER_COUNT_EN only)

module fifo_reader #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_re,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [CNT_SIZE-1:0]  words_out
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [1:0]           occ;
    logic                 inflight;
    logic [DATA_SIZE-1:0] head;
    logic [DATA_SIZE-1:0] skid;

    logic                 pop;
    logic                 cap;
    logic [2:0]           fill_after_pop;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign busy    = (state != IDLE);

    assign pop = m_valid & m_ready;
    assign cap = inflight;

    // Buffer entries committed once this cycle's pop is taken into account; pop
    // implies occ >= 1, so this never underflows.
    assign fill_after_pop = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Reads are only issued in RUN: IDLE and DRAIN never start new reads.
    assign fifo_re = enable & ~fifo_empty & (state == RUN) & (fill_after_pop < 3'd2);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = ((occ != 2'd0) || inflight) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if ((occ == 2'd0) && !inflight) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fifo_re;
        end
    end

    // Two-entry buffer. On a pop the skid word moves to head on the same edge; a
    // returning word lands in the first free slot after the pop is accounted for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            skid <= '0;
        end else begin
            case ({pop, cap})
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= fifo_data;
                    end else begin
                        head <= skid;
                        skid <= fifo_data;
                    end
                end
                2'b10: begin
                    head <= skid;
                    occ  <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        head <= fifo_data;
                    end else begin
                        skid <= fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard testbench for fifo_reader with a behavioural FIFO model

module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_re;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       busy;
    logic [3:0] words_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int re_cnt, first_re, last_re;
    int pop_cnt, first_pop, last_pop;

    fifo_reader #(.DATA_SIZE(8), .CNT_SIZE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_re    (fifo_re),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
`ifdef FIFO_READER_COUNT_EN
        ,
        .words_out  (words_out)
`endif
    );

`ifndef FIFO_READER_COUNT_EN
    assign words_out = 4'd0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO model: one-cycle read latency; empty flag settles shortly after each edge.
    always begin
        @(posedge clk);
        if (fifo_re && fifo_q.size() != 0) begin
            fifo_data <= fifo_q.pop_front();
        end
        #2;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_re) begin
                re_cnt++;
                if (re_cnt == 1) first_re = cyc;
                last_re = cyc;
                check("re_while_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_valid", {24'd0, m_data}, 32'hFFFF);
                end else begin
                    check("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
                end
                if (m_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    pop_cnt++;
                    if (pop_cnt == 1) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
    end

    task automatic clear_stats();
        re_cnt = 0; first_re = 0; last_re = 0;
        pop_cnt = 0; first_pop = 0; last_pop = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic wait_drain(input int limit, input bit rnd_ready);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
            tick(1);
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        end
        check("drain_timeout", exp_q.size(), 0);
        m_ready = 1'b1;
    endtask

    initial begin
        clear_stats();
        tick(1);
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_m_data", {24'd0, m_data}, 0);
        check("rst_fifo_re", {31'd0, fifo_re}, 0);
        check("rst_busy", {31'd0, busy}, 0);
`ifdef FIFO_READER_COUNT_EN
        check("rst_words_out", {28'd0, words_out}, 0);
`endif

        // Three preloaded words at full rate.
        do_reset();
        load(8'h11); load(8'h22); load(8'h33);
        tick(1);
        enable = 1'b1;
        wait_drain(30, 1'b0);
        check("t1_re_cnt", re_cnt, 3);
        check("t1_re_span", last_re - first_re, 2);
        check("t1_latency", first_pop - first_re, 2);
        check("t1_pop_span", last_pop - first_pop, 2);
`ifdef FIFO_READER_COUNT_EN
        check("t1_words_out", {28'd0, words_out}, 3);
`endif
        enable = 1'b0;
        tick(3);
        check("t1_idle_busy", {31'd0, busy}, 0);

        // Backpressure: only two reads until the buffer drains.
        do_reset();
        m_ready = 1'b0;
        load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
        tick(1);
        enable = 1'b1;
        tick(10);
        check("t2_re_cnt_stalled", re_cnt, 2);
        check("t2_valid_held", {31'd0, m_valid}, 1);
        check("t2_head_held", {24'd0, m_data}, 32'hA1);
        m_ready = 1'b1;
        wait_drain(30, 1'b0);
        check("t2_pop_cnt", pop_cnt, 4);
        check("t2_re_cnt", re_cnt, 4);
        enable = 1'b0;
        tick(3);

        // Empty FIFO while enabled.
        do_reset();
        enable = 1'b1;
        tick(6);
        check("t3_re_cnt", re_cnt, 0);
        check("t3_m_valid", {31'd0, m_valid}, 0);
        check("t3_busy", {31'd0, busy}, 1);
        enable = 1'b0;
        tick(3);

        // Enable dropped the cycle after a read.
        do_reset();
        load(8'h5C);
        tick(1);
        enable = 1'b1;
        for (int i = 0; i < 20 && !fifo_re; i++) tick(1);
        check("t4_saw_re", {31'd0, fifo_re}, 1);
        tick(1);
        enable = 1'b0;
        check("t4_busy_run", {31'd0, busy}, 1);
        tick(1);
        check("t4_busy_drain", {31'd0, busy}, 1);
        check("t4_valid_drain", {31'd0, m_valid}, 1);
        wait_drain(10, 1'b0);
        tick(3);
        check("t4_busy_idle", {31'd0, busy}, 0);
        check("t4_re_cnt", re_cnt, 1);

        // Reset while the buffer is full.
        do_reset();
        m_ready = 1'b0;
        load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
        tick(1);
        enable = 1'b1;
        tick(6);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, m_valid}, 0);
        check("t5_rst_busy", {31'd0, busy}, 0);
`ifdef FIFO_READER_COUNT_EN
        check("t5_rst_words_out", {28'd0, words_out}, 0);
`endif
        fifo_q.delete();
        exp_q.delete();
        enable = 1'b0;
        tick(2);
        rst = 1'b0;
        clear_stats();
        m_ready = 1'b1;
        enable = 1'b1;
        tick(5);
        check("t5_no_stale", pop_cnt, 0);
        load(8'h5A);
        wait_drain(20, 1'b0);
        check("t5_fresh_pop", pop_cnt, 1);
        enable = 1'b0;
        tick(3);

        // Seventeen words with random backpressure; 4-bit count wraps to 1.
        do_reset();
        for (int i = 0; i < 17; i++) load(8'($urandom_range(0, 255)));
        tick(1);
        enable = 1'b1;
        wait_drain(400, 1'b1);
        check("t6_pop_cnt", pop_cnt, 17);
`ifdef FIFO_READER_COUNT_EN
        check("t6_words_out_wrap", {28'd0, words_out}, 1);
`endif
        enable = 1'b0;
        tick(4);
        check("t6_idle", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
